// File: rtl/ulpi_pkg.sv
// rtl/ulpi_pkg.sv - shared types for the ULPI receive framer
package ulpi_pkg;

   // RxEvent field of an RX CMD byte
   typedef enum logic [1:0] {
      EV_NONE   = 2'b00,
      EV_ACTIVE = 2'b01,
      EV_DISC   = 2'b10,
      EV_ERROR  = 2'b11
   } rx_event_e;

   // RX CMD byte layout, MSB first
   typedef struct packed {
      logic [1:0] id;
      rx_event_e  rx_event;
      logic [1:0] vbus;
      logic [1:0] line;
   } rxcmd_t;

   // One FIFO entry as seen by the consumer
   typedef struct packed {
      logic       err;
      logic       eop;
      logic       sop;
      logic [7:0] data;
   } rx_entry_t;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'b00,
      ST_ACTIVE = 2'b01,
      ST_DROP   = 2'b10
   } framer_state_e;

   // Entry that closes a packet which lost data or carried only an error
   localparam rx_entry_t MARKER = '{err: 1'b1, eop: 1'b1, sop: 1'b0, data: 8'h00};

   // RxActive and RxError both mean the PHY is receiving
   function automatic logic ev_is_active(input rx_event_e ev);
      return (ev == EV_ACTIVE) || (ev == EV_ERROR);
   endfunction

endpackage

// File: rtl/ulpi_rx_fifo.sv
// rtl/ulpi_rx_fifo.sv - synchronous FIFO with push/full, pop/empty and registered head
module ulpi_rx_fifo
   import ulpi_pkg::*;
#(
   parameter int  DEPTH = 8,
   parameter type T     = rx_entry_t
) (
   input  logic clk,
   input  logic reset,
   input  logic push_i,
   input  T     push_data_i,
   output logic full_o,
   input  logic pop_i,
   output logic empty_o,
   output T     head_o
);

   localparam int AW = $clog2(DEPTH);

   T           mem_q [DEPTH];
   logic [AW:0] wr_q;
   logic [AW:0] rd_q;
   logic        do_push;
   logic        do_pop;

   // Extra pointer bit distinguishes full from empty when the indices match
   assign empty_o = (wr_q == rd_q);
   assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
   assign do_pop  = pop_i & ~empty_o;
   // A pop in the same cycle frees the slot, so a push into a full FIFO still lands
   assign do_push = push_i & (~full_o | do_pop);
   // Head reads as zero while empty so the outputs are quiet after reset
   assign head_o  = empty_o ? T'('0) : mem_q[rd_q[AW-1:0]];

   // Pointer update, wrapping modulo DEPTH through natural overflow
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_q <= '0;
         rd_q <= '0;
      end else begin
         if (do_push) wr_q <= wr_q + 1'b1;
         if (do_pop)  rd_q <= rd_q + 1'b1;
      end
   end

   // Storage write; contents need no reset because the pointers gate visibility
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_q[AW-1:0]] <= push_data_i;
   end

endmodule

// File: rtl/ulpi_rx_framer.sv
// rtl/ulpi_rx_framer.sv - splits ULPI receive bytes into RX CMD status and framed packets
module ulpi_rx_framer
   import ulpi_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             rx_dir,
   input  logic             rx_valid,
   input  logic             rx_is_cmd,
   input  logic [7:0]       rx_data,
   output logic             pkt_valid,
   input  logic             pkt_ready,
   output logic [7:0]       pkt_data,
   output logic             pkt_sop,
   output logic             pkt_eop,
   output logic             pkt_err,
   output logic [1:0]       line_state,
   output logic [1:0]       vbus_state,
   output logic             host_disc,
   output logic             rxcmd_strobe,
   output logic [CNT_W-1:0] ovf_count
);

   framer_state_e    state_q, state_d;
   logic             h_valid_q, h_valid_d;
   logic             h_sop_q, h_sop_d;
   logic [7:0]       h_data_q, h_data_d;
   logic             err_acc_q, err_acc_d;
   logic             pend_q, pend_d;
   logic [CNT_W-1:0] ovf_q, ovf_d;
   logic             ovf_inc;
   logic             rx_dir_q;
   logic [1:0]       line_q, vbus_q;
   logic             disc_q, strobe_q;

   logic             push;
   rx_entry_t        push_entry;
   rx_entry_t        head;
   logic             fifo_full, fifo_empty, pop, room;

   logic             cmd_v, data_v, ev_act, ev_err, pkt_end;
   rx_event_e        cmd_ev;

   assign cmd_ev  = rx_event_e'(rx_data[5:4]);
   assign cmd_v   = rx_valid & rx_is_cmd;
   assign data_v  = rx_valid & ~rx_is_cmd;
   assign ev_act  = cmd_v & ev_is_active(cmd_ev);
   assign ev_err  = cmd_v & (cmd_ev == EV_ERROR);
   // Packet ends on an inactive RxEvent or when the PHY hands the bus back
   assign pkt_end = (cmd_v & ~ev_is_active(cmd_ev)) | (rx_dir_q & ~rx_dir);

   assign pop  = pkt_valid & pkt_ready;
   assign room = ~fifo_full | (pop & ~fifo_empty);

   ulpi_rx_fifo #(.DEPTH(DEPTH), .T(rx_entry_t)) u_fifo (
      .clk         (clk),
      .reset       (reset),
      .push_i      (push),
      .push_data_i (push_entry),
      .full_o      (fifo_full),
      .pop_i       (pop),
      .empty_o     (fifo_empty),
      .head_o      (head)
   );

   assign pkt_valid                          = ~fifo_empty;
   assign {pkt_err, pkt_eop, pkt_sop, pkt_data} = head;
   assign line_state   = line_q;
   assign vbus_state   = vbus_q;
   assign host_disc    = disc_q;
   assign rxcmd_strobe = strobe_q;
   assign ovf_count    = ovf_q;

   // Framer next state: one-byte lookahead in H so the last byte can carry eop
   always_comb begin
      state_d    = state_q;
      h_valid_d  = h_valid_q;
      h_sop_d    = h_sop_q;
      h_data_d   = h_data_q;
      err_acc_d  = err_acc_q;
      pend_d     = pend_q;
      ovf_inc    = 1'b0;
      push       = 1'b0;
      push_entry = '0;
      case (state_q)
         ST_IDLE: begin
            if (pend_q) begin
               push       = 1'b1;
               push_entry = MARKER;
               if (room) pend_d = 1'b0;
               if (data_v) ovf_inc = 1'b1;
            end else if (ev_act) begin
               state_d   = ST_ACTIVE;
               h_valid_d = 1'b0;
               err_acc_d = ev_err;
            end
         end
         ST_ACTIVE: begin
            if (pkt_end) begin
               state_d   = ST_IDLE;
               h_valid_d = 1'b0;
               if (h_valid_q) begin
                  push       = 1'b1;
                  push_entry = '{err: err_acc_q, eop: 1'b1, sop: h_sop_q, data: h_data_q};
                  if (!room) begin
                     ovf_inc = 1'b1;
                     pend_d  = 1'b1;
                  end
               end else if (err_acc_q) begin
                  push       = 1'b1;
                  push_entry = MARKER;
                  if (!room) pend_d = 1'b1;
               end
            end else begin
               if (ev_err) err_acc_d = 1'b1;
               if (data_v) begin
                  if (!h_valid_q) begin
                     // H is only empty in ACTIVE before the first byte
                     h_valid_d = 1'b1;
                     h_sop_d   = 1'b1;
                     h_data_d  = rx_data;
                  end else begin
                     push       = 1'b1;
                     push_entry = '{err: 1'b0, eop: 1'b0, sop: h_sop_q, data: h_data_q};
                     if (room) begin
                        h_sop_d  = 1'b0;
                        h_data_d = rx_data;
                     end else begin
                        ovf_inc   = 1'b1;
                        h_valid_d = 1'b0;
                        state_d   = ST_DROP;
                     end
                  end
               end
            end
         end
         ST_DROP: begin
            if (pkt_end) begin
               state_d    = ST_IDLE;
               push       = 1'b1;
               push_entry = MARKER;
               if (!room) pend_d = 1'b1;
            end else if (data_v) begin
               ovf_inc = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      ovf_d = (ovf_inc && (ovf_q != {CNT_W{1'b1}})) ? ovf_q + 1'b1 : ovf_q;
   end

   // Framer state, hold register and overflow counter
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         h_valid_q <= 1'b0;
         h_sop_q   <= 1'b0;
         h_data_q  <= '0;
         err_acc_q <= 1'b0;
         pend_q    <= 1'b0;
         ovf_q     <= '0;
         rx_dir_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         h_valid_q <= h_valid_d;
         h_sop_q   <= h_sop_d;
         h_data_q  <= h_data_d;
         err_acc_q <= err_acc_d;
         pend_q    <= pend_d;
         ovf_q     <= ovf_d;
         rx_dir_q  <= rx_dir;
      end
   end

   // Line status captured from every RX CMD, with a strobe marking the update
   always_ff @(posedge clk) begin
      if (reset) begin
         line_q   <= '0;
         vbus_q   <= '0;
         disc_q   <= 1'b0;
         strobe_q <= 1'b0;
      end else begin
         strobe_q <= cmd_v;
         if (cmd_v) begin
            line_q <= rx_data[1:0];
            vbus_q <= rx_data[3:2];
            disc_q <= (cmd_ev == EV_DISC);
         end
      end
   end

endmodule

// File: tb/tb_ulpi_rx_framer.sv
// tb/tb_ulpi_rx_framer.sv - self-checking bench for ulpi_rx_framer
module tb_ulpi_rx_framer;
   import ulpi_pkg::*;

   localparam int DEPTH = 8;
   localparam int CNT_W = 8;

   logic clk = 1'b0;
   logic reset, rx_dir, rx_valid, rx_is_cmd, pkt_ready;
   logic [7:0] rx_data;
   logic pkt_valid, pkt_sop, pkt_eop, pkt_err, host_disc, rxcmd_strobe;
   logic [7:0] pkt_data;
   logic [1:0] line_state, vbus_state;
   logic [CNT_W-1:0] ovf_count;

   int checks = 0;
   int errors = 0;
   int strobes = 0;
   bit rand_ready = 0;
   logic [10:0] got_q[$];
   logic [10:0] exp_q[$];

   ulpi_rx_framer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk(clk), .reset(reset), .rx_dir(rx_dir), .rx_valid(rx_valid),
      .rx_is_cmd(rx_is_cmd), .rx_data(rx_data), .pkt_valid(pkt_valid),
      .pkt_ready(pkt_ready), .pkt_data(pkt_data), .pkt_sop(pkt_sop),
      .pkt_eop(pkt_eop), .pkt_err(pkt_err), .line_state(line_state),
      .vbus_state(vbus_state), .host_disc(host_disc),
      .rxcmd_strobe(rxcmd_strobe), .ovf_count(ovf_count)
   );

   always #5 clk = ~clk;

   // Record accepted entries and strobe pulses; a handshake seen here completes at the next edge
   always @(negedge clk) begin
      if (!reset) begin
         if (pkt_valid && pkt_ready) got_q.push_back({pkt_err, pkt_eop, pkt_sop, pkt_data});
         if (rxcmd_strobe) strobes++;
      end
   end

   function automatic logic [10:0] ent(input bit e, input bit eo, input bit s, input logic [7:0] d);
      return {e, eo, s, d};
   endfunction

   task automatic step(input logic v, input logic c, input logic [7:0] d);
      rx_valid = v; rx_is_cmd = c; rx_data = d;
      if (rand_ready) pkt_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      rx_valid = 1'b0; rx_is_cmd = 1'b0;
   endtask

   task automatic cmd(input logic [7:0] b);  step(1'b1, 1'b1, b); endtask
   task automatic dat(input logic [7:0] b);  step(1'b1, 1'b0, b); endtask
   task automatic idle(input int n);         repeat (n) step(1'b0, 1'b0, 8'h00); endtask

   task automatic dir_fall();
      rx_dir = 1'b0;
      step(1'b0, 1'b0, 8'h00);
      rx_dir = 1'b1;
   endtask

   task automatic drain(output bit timed_out);
      bit save;
      save = rand_ready; rand_ready = 0; pkt_ready = 1'b1;
      for (int i = 0; i < 400; i++) begin
         if (!pkt_valid && got_q.size() >= exp_q.size()) break;
         idle(1);
      end
      idle(2);
      timed_out = pkt_valid || (got_q.size() < exp_q.size());
      rand_ready = save;
   endtask

   task automatic test_reset();
      reset = 1'b1; rx_dir = 1'b1; rx_valid = 1'b0; rx_is_cmd = 1'b0; rx_data = 8'h00; pkt_ready = 1'b0;
      repeat (3) begin @(posedge clk); #1; end
      checks++;
      if ({pkt_valid, pkt_sop, pkt_eop, pkt_err, pkt_data} !== 12'h000) begin
         errors++; $display("FAIL reset_pkt got %b%b%b%b %h required 0", pkt_valid, pkt_sop, pkt_eop, pkt_err, pkt_data);
      end
      checks++;
      if ({line_state, vbus_state, host_disc, rxcmd_strobe, ovf_count} !== 14'h0) begin
         errors++; $display("FAIL reset_status got %b %b %b %b %h required 0", line_state, vbus_state, host_disc, rxcmd_strobe, ovf_count);
      end
      reset = 1'b0;
      idle(1);
   endtask

   task automatic test_basic();
      int s0; bit to;
      pkt_ready = 1'b0; s0 = strobes;
      cmd(8'h11); dat(8'h11); dat(8'h22); dat(8'h33); cmd(8'h01); idle(1);
      checks++;
      if (line_state !== 2'b01) begin errors++; $display("FAIL basic_line got %b required 01", line_state); end
      checks++;
      if (strobes - s0 !== 2) begin errors++; $display("FAIL basic_strobes got %0d required 2", strobes - s0); end
      exp_q = '{ent(0, 0, 1, 8'h11), ent(0, 0, 0, 8'h22), ent(0, 1, 0, 8'h33)};
      drain(to);
      checks++;
      if (to || got_q.size() != exp_q.size()) begin
         errors++; $display("FAIL basic_count got %0d required %0d", got_q.size(), exp_q.size());
      end else foreach (exp_q[i]) begin
         checks++;
         if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL basic_entry%0d got %h required %h", i, got_q[i], exp_q[i]); end
      end
      got_q.delete(); exp_q.delete();
   endtask

   task automatic test_error();
      bit to;
      pkt_ready = 1'b0;
      cmd(8'h31); dat(8'hAA); dat(8'hBB); cmd(8'h00);
      exp_q = '{ent(0, 0, 1, 8'hAA), ent(1, 1, 0, 8'hBB)};
      drain(to);
      checks++;
      if (to || got_q.size() != exp_q.size()) begin
         errors++; $display("FAIL error_count got %0d required %0d", got_q.size(), exp_q.size());
      end else foreach (exp_q[i]) begin
         checks++;
         if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL error_entry%0d got %h required %h", i, got_q[i], exp_q[i]); end
      end
      got_q.delete(); exp_q.delete();
      cmd(8'h26); idle(1);
      checks++;
      if ({host_disc, vbus_state, line_state} !== 5'b1_01_10) begin
         errors++; $display("FAIL disc_status got %b%b%b required 10110", host_disc, vbus_state, line_state);
      end
   endtask

   task automatic test_dir_fall();
      bit to;
      pkt_ready = 1'b0;
      cmd(8'h11); dat(8'h5A);
      checks++;
      if (pkt_valid !== 1'b0) begin errors++; $display("FAIL dirfall_early got %b required 0", pkt_valid); end
      dir_fall();
      checks++;
      if ({pkt_valid, pkt_err, pkt_eop, pkt_sop, pkt_data} !== {4'b1011, 8'h5A}) begin
         errors++; $display("FAIL dirfall_head got %b%b%b%b %h required 1011 5a", pkt_valid, pkt_err, pkt_eop, pkt_sop, pkt_data);
      end
      exp_q = '{ent(0, 1, 1, 8'h5A)};
      drain(to);
      checks++;
      if (to || got_q.size() != 1 || got_q[0] !== exp_q[0]) begin
         errors++; $display("FAIL dirfall_stream got %0d entries required 1 (%h)", got_q.size(), exp_q[0]);
      end
      got_q.delete(); exp_q.delete();
   endtask

   task automatic test_zero_len();
      bit to;
      pkt_ready = 1'b0;
      cmd(8'h11); cmd(8'h00); idle(2);
      checks++;
      if (pkt_valid !== 1'b0) begin errors++; $display("FAIL zero_len_clean got %b required 0", pkt_valid); end
      cmd(8'h31); cmd(8'h00);
      checks++;
      if ({pkt_valid, pkt_err, pkt_eop, pkt_sop, pkt_data} !== {4'b1110, 8'h00}) begin
         errors++; $display("FAIL zero_len_marker got %b%b%b%b %h required 1110 00", pkt_valid, pkt_err, pkt_eop, pkt_sop, pkt_data);
      end
      exp_q = '{ent(1, 1, 0, 8'h00)};
      drain(to);
      checks++;
      if (to || got_q.size() != 1 || got_q[0] !== exp_q[0]) begin
         errors++; $display("FAIL zero_len_stream got %0d entries required 1", got_q.size());
      end
      got_q.delete(); exp_q.delete();
   endtask

   task automatic test_overflow();
      bit to; logic [10:0] head0;
      pkt_ready = 1'b0;
      cmd(8'h11);
      for (int i = 0; i < 12; i++) dat(8'h40 + 8'(i));
      cmd(8'h01);
      checks++;
      if (ovf_count !== 8'd3) begin errors++; $display("FAIL ovf_count got %0d required 3", ovf_count); end
      // A new packet while the marker is still owed is refused and its bytes counted
      cmd(8'h11);
      for (int i = 0; i < 300; i++) dat(8'($urandom));
      cmd(8'h01);
      checks++;
      if (ovf_count !== 8'hFF) begin errors++; $display("FAIL ovf_saturate got %0d required 255", ovf_count); end
      head0 = {pkt_err, pkt_eop, pkt_sop, pkt_data};
      idle(3);
      checks++;
      if ({pkt_valid, pkt_err, pkt_eop, pkt_sop, pkt_data} !== {1'b1, 11'h140}) begin
         errors++; $display("FAIL ovf_hold got %b %h then %h required 1 140", pkt_valid, head0, {pkt_err, pkt_eop, pkt_sop, pkt_data});
      end
      for (int i = 0; i < DEPTH; i++) exp_q.push_back(ent(0, 0, i == 0, 8'h40 + 8'(i)));
      exp_q.push_back(ent(1, 1, 0, 8'h00));
      drain(to);
      checks++;
      if (to || got_q.size() != exp_q.size()) begin
         errors++; $display("FAIL ovf_drain_count got %0d required %0d", got_q.size(), exp_q.size());
      end else foreach (exp_q[i]) begin
         checks++;
         if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL ovf_entry%0d got %h required %h", i, got_q[i], exp_q[i]); end
      end
      got_q.delete(); exp_q.delete();
   endtask

   task automatic test_back_to_back();
      bit to;
      pkt_ready = 1'b1;
      cmd(8'h11); dat(8'hA1); dat(8'hA2); cmd(8'h00);
      cmd(8'h11); dat(8'hB1); cmd(8'h01);
      exp_q = '{ent(0, 0, 1, 8'hA1), ent(0, 1, 0, 8'hA2), ent(0, 1, 1, 8'hB1)};
      drain(to);
      checks++;
      if (to || got_q.size() != exp_q.size()) begin
         errors++; $display("FAIL b2b_count got %0d required %0d", got_q.size(), exp_q.size());
      end else foreach (exp_q[i]) begin
         checks++;
         if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL b2b_entry%0d got %h required %h", i, got_q[i], exp_q[i]); end
      end
      got_q.delete(); exp_q.delete();
   endtask

   task automatic test_random();
      rxcmd_t c, last; int len, ncmd, s0; bit err, to; logic [7:0] b;
      ncmd = 0; s0 = strobes; rand_ready = 1; last = '0;
      for (int p = 0; p < 40; p++) begin
         repeat ($urandom_range(0, 2)) dat(8'($urandom));
         len = $urandom_range(0, 8);
         err = ($urandom_range(0, 3) == 0);
         c.id = 2'($urandom); c.vbus = 2'($urandom); c.line = 2'($urandom);
         c.rx_event = err ? EV_ERROR : EV_ACTIVE;
         cmd(c); last = c; ncmd++;
         for (int i = 0; i < len; i++) begin
            if ($urandom_range(0, 5) == 0) begin
               c.rx_event = ($urandom_range(0, 1) == 1) ? EV_ERROR : EV_ACTIVE;
               if (c.rx_event == EV_ERROR) err = 1;
               c.line = 2'($urandom);
               cmd(c); last = c; ncmd++;
            end
            if ($urandom_range(0, 3) == 0) idle(1);
            b = 8'($urandom);
            dat(b);
            exp_q.push_back(ent(err && (i == len - 1), i == len - 1, i == 0, b));
         end
         if (len == 0 && err) exp_q.push_back(ent(1, 1, 0, 8'h00));
         case ($urandom_range(0, 2))
            0: begin c.rx_event = EV_NONE; c.vbus = 2'($urandom); cmd(c); last = c; ncmd++; end
            1: begin c.rx_event = EV_DISC; c.line = 2'($urandom); cmd(c); last = c; ncmd++; end
            default: dir_fall();
         endcase
         drain(to);
         checks++;
         if (to || {line_state, vbus_state, host_disc} !== {last.line, last.vbus, last.rx_event == EV_DISC}) begin
            errors++; $display("FAIL rand_status pkt%0d got %b %b %b required %b %b %b", p,
               line_state, vbus_state, host_disc, last.line, last.vbus, last.rx_event == EV_DISC);
         end
      end
      rand_ready = 0;
      checks++;
      if (strobes - s0 !== ncmd) begin errors++; $display("FAIL rand_strobes got %0d required %0d", strobes - s0, ncmd); end
      checks++;
      if (got_q.size() != exp_q.size()) begin
         errors++; $display("FAIL rand_count got %0d required %0d", got_q.size(), exp_q.size());
      end else foreach (exp_q[i]) begin
         checks++;
         if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL rand_entry%0d got %h required %h", i, got_q[i], exp_q[i]); end
      end
      got_q.delete(); exp_q.delete();
   endtask

   task automatic test_reset_mid_packet();
      bit to;
      pkt_ready = 1'b0;
      cmd(8'h11); dat(8'h01); dat(8'h02); dat(8'h03);
      reset = 1'b1;
      idle(1);
      checks++;
      if (pkt_valid !== 1'b0 || ovf_count !== '0) begin
         errors++; $display("FAIL reset_mid got valid %b ovf %0d required 0 0", pkt_valid, ovf_count);
      end
      reset = 1'b0;
      got_q.delete();
      idle(1);
      cmd(8'h11); dat(8'h77); cmd(8'h00);
      exp_q = '{ent(0, 1, 1, 8'h77)};
      drain(to);
      checks++;
      if (to || got_q.size() != 1 || got_q[0] !== exp_q[0]) begin
         errors++; $display("FAIL reset_next_pkt got %0d entries required 1 (%h)", got_q.size(), exp_q[0]);
      end
      got_q.delete(); exp_q.delete();
   endtask

   initial begin
      test_reset();
      test_basic();
      test_error();
      test_dir_fall();
      test_zero_len();
      test_back_to_back();
      test_random();
      test_overflow();
      test_reset_mid_packet();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
